// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field position, opcode map and NOP.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  localparam int OPC_MSB = INSTR_W_DEF - 1;
  localparam int OPC_LSB = INSTR_W_DEF - 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_AND   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_JUMP  = 4'b1000,
    OP_HALT  = 4'b1111
  } opcode_e;

  localparam logic [INSTR_W_DEF-1:0] NOP = {OP_NOP, {(INSTR_W_DEF-4){1'b0}}};

  function automatic opcode_e opcode_of(input logic [INSTR_W_DEF-1:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter: reset > jump > hold on stall > +1 with natural wrap at 2^ADDR_W.
// Output forced to RESET_PC combinationally while rst is high so the fetch address is clean.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    if (rst)
      w_pc_nxt = RST_PC;
    else if (jump_en)
      w_pc_nxt = jump_target;
    else if (!stall)
      w_pc_nxt = r_pc + 1'b1;
  end

  always_ff @(posedge clk) begin
    r_pc <= w_pc_nxt;
  end

  assign pc = rst ? RST_PC : r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage + IF/ID register: 2-cycle reset-to-instruction latency, one instruction per cycle.
// Stall freezes pc/fetch slot/IF/ID without issuing a read; jump wins over stall and flushes two slots.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  logic [ADDR_W-1:0]  w_pc;
  logic [INSTR_W-1:0] w_f_instr;

  logic               r_rd_live;
  logic [INSTR_W-1:0] r_hold_instr;
  logic [ADDR_W-1:0]  r_f_pc;
  logic               r_f_valid;
  logic [INSTR_W-1:0] r_id_instr;
  logic [ADDR_W-1:0]  r_id_pc;
  logic               r_id_valid;

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .pc          (w_pc)
  );

  assign imem_addr = w_pc;
  assign imem_en   = !rst && (!stall || jump_en);

  // Memory data is only valid the cycle after a read; afterwards the hold copy stands in.
  assign w_f_instr = r_rd_live ? imem_rdata : r_hold_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_live    <= 1'b0;
      r_hold_instr <= '0;
      r_f_pc       <= '0;
      r_f_valid    <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_id_valid   <= 1'b0;
    end else begin
      r_rd_live <= imem_en;
      if (r_rd_live)
        r_hold_instr <= imem_rdata;
      if (jump_en) begin
        r_f_valid  <= 1'b0;
        r_id_valid <= 1'b0;
      end else if (!stall) begin
        r_id_instr <= w_f_instr;
        r_id_pc    <= r_f_pc;
        r_id_valid <= r_f_valid;
        r_f_pc     <= w_pc;
        r_f_valid  <= 1'b1;
      end
    end
  end

  assign if_id_instr = r_id_instr;
  assign if_id_pc    = r_id_pc;
  assign if_id_valid = r_id_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized + directed bench for inst_fetch against a two-slot address-stream model and a synchronous ROM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_target = 8'h00;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] if_id_instr;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [256];

  // Expected stream: fetch slot and IF/ID as (address, valid) pairs; data comes from the ROM table.
  logic [7:0] m_pc = 8'h00;
  logic       m_fv = 1'b0;
  logic [7:0] m_fpc = 8'h00;
  logic       m_idv = 1'b0;
  logic [7:0] m_idpc = 8'h00;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  // Data outside the read-latency window is scrambled so stale bus values are never usable.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
    else         imem_rdata <= 16'($urandom);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic [7:0] t);
    @(negedge clk);
    rst = r; stall = s; jump_en = j; jump_target = t;
    #1;
    check_val("imem_en", {31'd0, imem_en}, {31'd0, (!r && (!s || j))});
    check_val("imem_addr", {24'd0, imem_addr}, {24'd0, (r ? 8'h00 : m_pc)});
    @(posedge clk);
    if (r) begin
      m_pc = 8'h00; m_fv = 1'b0; m_fpc = 8'h00; m_idv = 1'b0; m_idpc = 8'h00;
    end else if (j) begin
      m_pc = t; m_fv = 1'b0; m_idv = 1'b0;
    end else if (!s) begin
      m_idv = m_fv; m_idpc = m_fpc;
      m_fv = 1'b1; m_fpc = m_pc;
      m_pc = m_pc + 8'd1;
    end
    #1;
    check_val("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_idv});
    if (m_idv) begin
      check_val("if_id_pc", {24'd0, if_id_pc}, {24'd0, m_idpc});
      check_val("if_id_instr", {16'd0, if_id_instr}, {16'd0, rom[m_idpc]});
    end
    if (r) begin
      check_val("rst_instr", {16'd0, if_id_instr}, 32'd0);
      check_val("rst_pc", {24'd0, if_id_pc}, 32'd0);
    end
  endtask

  task automatic run_until_pc(input logic [7:0] target);
    int n = 0;
    while (!(m_idv && m_idpc == target) && n < 600) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    check_val("wait_pc_bound", {31'd0, (n < 600)}, 32'd1);
  endtask

  // Drops reset and measures cycles until the first valid instruction reaches IF/ID.
  task automatic release_and_measure(input string tag);
    int lat = 0;
    while (if_id_valid !== 1'b1 && lat < 10) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lat++;
    end
    check_val(tag, lat, 2);
    check_val({tag, "_instr"}, {16'd0, if_id_instr}, 32'h0000A000);
    check_val({tag, "_pc"}, {24'd0, if_id_pc}, 32'd0);
  endtask

  int a004_cycles;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    release_and_measure("first_latency");

    // Stall while A004 sits in IF/ID: it must be held four cycles in total.
    run_until_pc(8'h04);
    a004_cycles = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (if_id_valid && if_id_instr == 16'hA004) a004_cycles++;
    end
    check_val("stall_hold_cycles", a004_cycles, 4);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("after_stall_instr", {16'd0, if_id_instr}, 32'h0000A005);

    // Jump from pc 5 to 0x40: two bubbles, then 0x40, 0x41.
    step(1'b0, 1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("jump_arrive_pc", {24'd0, if_id_pc}, 32'h40);
    check_val("jump_arrive_v", {31'd0, if_id_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Jump together with stall, then a stall right after the jump.
    step(1'b0, 1'b1, 1'b1, 8'h20);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("jstall_arrive_pc", {24'd0, if_id_pc}, 32'h20);

    // Wrap of the address space: FE, FF, 00, 01.
    step(1'b0, 1'b0, 1'b1, 8'hFB);
    run_until_pc(8'hFE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("wrap_pc0", {24'd0, if_id_pc}, 32'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("wrap_pc1", {24'd0, if_id_pc}, 32'h01);

    // Reset pulse in the middle of a stall with a valid entry in IF/ID.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_val("midstall_rst_valid", {31'd0, if_id_valid}, 32'd0);
    release_and_measure("restart_latency");

    // Random traffic: mostly advancing, with stalls, jumps and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, j;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 9) == 0);
      step(r, s, j, 8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage. Owns the program counter, issues reads to a synchronous instruction memory with one-cycle read latency, and presents one instruction per cycle to decode. Decode consumes `if_id_instr[15:12]` as the opcode. Handles hazard-unit stalls without losing in-flight read data, and jump redirects from decode, with a wrong-path flush.

## Interface
- `ADDR_W`, 8: PC and instruction-memory address width.
- `INSTR_W`, 16: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
- `RESET_PC`, 0: PC value after reset.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard-unit request to hold fetch and IF/ID.
- `jump_en` in 1: decode resolved a taken jump this cycle.
- `jump_target` in ADDR_W: absolute target address; valid with `jump_en`.
- `imem_addr` out ADDR_W: read address, equal to `pc`.
- `imem_en` out 1: read enable.
- `imem_rdata` in INSTR_W: read data, valid the cycle after an enabled read.
- `if_id_instr` out INSTR_W: registered instruction to decode.
- `if_id_pc` out ADDR_W: address of `if_id_instr`.
- `if_id_valid` out 1: `if_id_instr` is a real instruction; 0 = bubble.

## Operation
- State:
  - `pc`.
  - Fetch slot: `f_pc`, `f_valid`, for the read in flight.
  - `rd_live`: `imem_en` delayed one cycle.
  - Hold buffer `hold_instr`.
  - IF/ID register.
- `imem_addr = pc`. `imem_en = !rst && (!stall || jump_en)`.
- Fetch-slot data: `f_instr = rd_live ? imem_rdata : hold_instr`. `hold_instr <= imem_rdata` on every cycle `rd_live` = 1, so data survives stalls.
- Priority: `rst` > `jump_en` > `stall` > advance.
- Advance (`!stall`, `!jump_en`):
  - IF/ID <= {`f_instr`, `f_pc`, `f_valid`}.
  - `f_pc <= pc`, `f_valid <= 1`.
  - `pc <= pc + 1`, mod 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
- Stall (`stall`, `!jump_en`): `pc`, fetch slot and IF/ID all hold. No read is issued.
- Jump (`jump_en`, regardless of `stall`):
  - `pc <= jump_target`, `f_valid <= 0`, `if_id_valid <= 0`.
  - Both wrong-path instructions (the IF/ID entry and the in-flight read) are discarded.
- `jump_en` is sampled without qualification; decode must gate it with its own valid.
- Reset (any cycle, including mid-stall or mid-jump):
  - `pc = RESET_PC`; `f_valid`, `rd_live`, `if_id_valid` = 0.
  - `if_id_instr`, `if_id_pc`, `hold_instr`, `f_pc` = 0.
  - `imem_en` = 0 and `imem_addr = RESET_PC` while `rst` is high.

## Timing
- First cycle with `rst` = 0 is C0: read of RESET_PC issued.
  - C1: data in fetch slot.
  - C2: `if_id_valid` = 1 with instr@RESET_PC.
  - Reset-to-first-instruction latency: 2 cycles.
- Steady state: one instruction per cycle; `if_id_pc` increments by 1 each cycle.
- Jump at cycle J: read of the target issued in J+1; target reaches IF/ID in J+3.
  - `if_id_valid` = 0 in J+1 and J+2: a two-bubble penalty.
- Stall of N cycles: IF/ID is frozen for N cycles. The instruction following is exactly the next in sequence, with no duplication or loss.
  - Back-to-back stalls, and a stall in the cycle after a jump, behave the same way.
- Bubbles (valid = 0) carry through IF/ID unchanged. `if_id_instr`/`if_id_pc` of a bubble are don't-care but must not be X after reset.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W`, `ADDR_W` defaults.
  - Opcode field position.
  - Opcode constants, incl. `OP_JUMP = 4'b1000`.
  - `NOP` encoding.
- One sub-module, `pc_gen`: owns `pc`, next-PC select (hold / +1 / `jump_target` / `RESET_PC`) and wrap.
- Fetch slot, hold buffer and IF/ID register live in `inst_fetch`.
- Memory model is external; the testbench supplies a synchronous ROM.

## Test plan
- Reset, then free-run with ROM[i] = 16'hA000+i -> `if_id_valid` rises 2 cycles after `rst` drops; `if_id_instr` = A000, A001, A002… with `if_id_pc` = 0, 1, 2.
- `stall` high 3 cycles while `if_id_pc` = 4 -> IF/ID holds A004 for 4 cycles total, then A005, A006 follow with none skipped or repeated; `imem_en` = 0 during the stall.
- `jump_en` = 1, `jump_target` = 8'h40 when `if_id_pc` = 5 -> two cycles of `if_id_valid` = 0, then `if_id_pc` = 0x40, 0x41; instr@6 and instr@7 never appear valid.
- `jump_en` together with `stall` (target 8'h20) -> jump wins; flush occurs; `if_id_pc` = 0x20 appears 3 cycles later.
- Run to `pc` = 8'hFE with no jumps -> `if_id_pc` sequence FE, FF, 00, 01.
- Assert `rst` for 1 cycle mid-stall with `if_id_valid` = 1 -> next cycle all valids = 0, `imem_addr` = RESET_PC; restart timing matches the first scenario.
